time_fmt_conv: RTL

//  Multi-channel, registered BCD hh:mm:ss display-format converter (12h AM/PM or 24h).

---
 rtl/time_fmt_conv_pkg.sv | 35 +++
 rtl/time_fmt_conv_if.sv | 26 ++
 rtl/time_fmt_conv_rr_arbiter.sv | 51 +++++
 rtl/time_fmt_conv.sv | 127 ++++++++++++
 4 files changed

// File: rtl/time_fmt_conv_pkg.sv
// Shared types and the pure BCD hour conversion for the time display converter.
package time_fmt_pkg;

  localparam int HOUR_MSB = 19;
  localparam int HOUR_LSB = 14;

  typedef struct packed {
    logic [1:0] h_t;
    logic [3:0] h_u;
    logic [2:0] m_t;
    logic [3:0] m_u;
    logic [2:0] s_t;
    logic [3:0] s_u;
  } bcd_time_t;

  // 24h BCD hour -> 12h BCD hour. An invalid hour returns unchanged with ok=0, pm=0.
  function automatic void hour_to_12h(input  logic [5:0] hour_bcd,
                                      output logic [5:0] h,
                                      output logic       pm,
                                      output logic       ok);
    logic [5:0] bin;
    logic [5:0] h12b;
    logic       tens;
    bin  = 6'(hour_bcd[5:4]) * 6'd10 + 6'(hour_bcd[3:0]);
    ok   = (hour_bcd[3:0] <= 4'd9) && (bin <= 6'd23);
    pm   = ok && (bin >= 6'd12);
    if (bin == 6'd0)       h12b = 6'd12;
    else if (bin > 6'd12)  h12b = bin - 6'd12;
    else                   h12b = bin;
    tens = (h12b >= 6'd10);
    if (ok) h = {1'b0, tens, tens ? 4'(h12b - 6'd10) : h12b[3:0]};
    else    h = hour_bcd;
  endfunction

endpackage

// File: rtl/time_fmt_conv_if.sv
// Source-side and display-side handshake bundle of the time format converter.
interface time_fmt_conv_if #(
  parameter int N_CH = 2,
  parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic [N_CH-1:0]                    in_valid;
  time_fmt_pkg::bcd_time_t [N_CH-1:0] in_time;
  logic [N_CH-1:0]                    in_ready;
  logic                               out_valid;
  logic                               out_ready;
  logic [CH_W-1:0]                    out_ch;
  time_fmt_pkg::bcd_time_t            out_time;
  logic                               out_pm;
  logic                               out_blank;
  logic                               out_err;

  modport master (
    output in_valid, in_time, out_ready,
    input  in_ready, out_valid, out_ch, out_time, out_pm, out_blank, out_err
  );

  modport slave (
    input  in_valid, in_time, out_ready,
    output in_ready, out_valid, out_ch, out_time, out_pm, out_blank, out_err
  );
endinterface

// File: rtl/time_fmt_conv_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer, cyclically.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             hi_found, lo_found;
  logic [IDX_W-1:0] hi_idx, lo_idx;

  // hi_* is the first request at/after the pointer; lo_* is the wrap-around fallback.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (req[k]) begin
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(k);
        end
        if (!hi_found && (IDX_W'(k) >= rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(k);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
    grant     = lo_found ? (N'(1) << grant_idx) : '0;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance && lo_found)
      rr_ptr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/time_fmt_conv.sv
// Multi-channel BCD hh:mm:ss converter: round-robin source select, 12h/24h format, one-stage output register.
module time_fmt_conv
  import time_fmt_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int BLANK_LZ = 1,
  parameter int ERR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_toggle,
  time_fmt_conv_if.slave    bus,
  output logic              mode12,
  output logic [ERR_W-1:0]  err_count
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] grant;
  logic [CH_W-1:0] grant_idx;
  logic            load_en, take;
  bcd_time_t       sel, conv;
  logic [19:0]     sel_word;
  logic [5:0]      h12;
  logic            pm12, hour_ok, conv_pm, conv_blank, conv_err;

  logic             out_valid_q, out_valid_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  bcd_time_t        out_time_q, out_time_d;
  logic             out_pm_q, out_pm_d;
  logic             out_blank_q, out_blank_d;
  logic             out_err_q, out_err_d;
  logic             mode12_q, mode12_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  assign load_en = !out_valid_q || bus.out_ready;
  assign take    = load_en && (|grant);

  rr_arbiter #(.N(N_CH), .IDX_W(CH_W)) u_arb (
    .clk       (clk),
    .rst       (reset),
    .req       (bus.in_valid),
    .advance   (load_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign bus.in_ready = grant & {N_CH{load_en}};

  always_comb begin
    sel = '0;
    for (int k = 0; k < N_CH; k++)
      if (grant[k]) sel = bus.in_time[k];
  end

  assign sel_word = sel;

  always_comb hour_to_12h(sel_word[HOUR_MSB:HOUR_LSB], h12, pm12, hour_ok);

  // Invalid hours pass through untouched in both modes; only valid 12h words are rewritten.
  always_comb begin
    conv       = sel;
    conv_pm    = 1'b0;
    conv_blank = 1'b0;
    conv_err   = !hour_ok;
    if (hour_ok && mode12_q) begin
      conv.h_t   = h12[5:4];
      conv.h_u   = h12[3:0];
      conv_pm    = pm12;
      conv_blank = (BLANK_LZ != 0) && (h12[5:4] == 2'd0);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_time_d  = out_time_q;
    out_pm_d    = out_pm_q;
    out_blank_d = out_blank_q;
    out_err_d   = out_err_q;
    mode12_d    = mode12_q ^ mode_toggle;
    err_count_d = err_count_q;
    if (take) begin
      out_valid_d = 1'b1;
      out_ch_d    = grant_idx;
      out_time_d  = conv;
      out_pm_d    = conv_pm;
      out_blank_d = conv_blank;
      out_err_d   = conv_err;
      if (conv_err && (err_count_q != '1)) err_count_d = err_count_q + ERR_W'(1);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_time_q  <= '0;
      out_pm_q    <= 1'b0;
      out_blank_q <= 1'b0;
      out_err_q   <= 1'b0;
      mode12_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_time_q  <= out_time_d;
      out_pm_q    <= out_pm_d;
      out_blank_q <= out_blank_d;
      out_err_q   <= out_err_d;
      mode12_q    <= mode12_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_time  = out_time_q;
  assign bus.out_pm    = out_pm_q;
  assign bus.out_blank = out_blank_q;
  assign bus.out_err   = out_err_q;
  assign mode12        = mode12_q;
  assign err_count     = err_count_q;

endmodule
